// File: rtl/imem_pkg.sv
// Shared constants, FSM states and grant encoding for the instruction-RAM arbiter.
package imem_pkg;

    localparam int IDX_W  = 14;
    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        RSP  = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        GNT_NONE  = 2'd0,
        GNT_FETCH = 2'd1,
        GNT_LOAD  = 2'd2
    } gnt_t;

endpackage

// File: rtl/imem_arbiter_if.sv
// Fetch, loader and RAM-side signals of the instruction-RAM arbiter.
// The arbiter uses the slave modport; the surrounding system uses master.
interface imem_arbiter_if;
    import imem_pkg::*;

    logic              f_req_valid;
    logic              f_req_ready;
    logic [31:0]       f_req_addr;
    logic              f_rsp_valid;
    logic              f_rsp_ready;
    logic [DATA_W-1:0] f_rsp_data;
    logic              f_rsp_err;
    logic              l_req_valid;
    logic              l_req_ready;
    logic [31:0]       l_req_addr;
    logic [DATA_W-1:0] l_req_data;
    logic              l_wr_ack;
    logic              mem_en;
    logic              mem_we;
    logic [IDX_W-1:0]  mem_idx;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  f_req_valid, f_req_addr, f_rsp_ready,
        input  l_req_valid, l_req_addr, l_req_data,
        input  mem_rdata,
        output f_req_ready, f_rsp_valid, f_rsp_data, f_rsp_err,
        output l_req_ready, l_wr_ack,
        output mem_en, mem_we, mem_idx, mem_wdata
    );

    modport master (
        output f_req_valid, f_req_addr, f_rsp_ready,
        output l_req_valid, l_req_addr, l_req_data,
        output mem_rdata,
        input  f_req_ready, f_rsp_valid, f_rsp_data, f_rsp_err,
        input  l_req_ready, l_wr_ack,
        input  mem_en, mem_we, mem_idx, mem_wdata
    );

endinterface

// File: rtl/imem_arb_sel.sv
// Requester selector: loader has strict priority; with IMEM_ARB_AGE_EN defined,
// fetch wins once STARVE_MAX consecutive loader grants were made while it waited.
module imem_arb_sel
    import imem_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic idle,
    input  logic f_req_valid,
    input  logic l_req_valid,
    output gnt_t gnt
);

`ifdef IMEM_ARB_AGE_EN
    localparam int CNT_W = $clog2(STARVE_MAX + 1);

    logic [CNT_W-1:0] starve_cnt_r;
    logic             age_win_s;

    assign age_win_s = f_req_valid && (starve_cnt_r == CNT_W'(STARVE_MAX));

    // Saturating count of loader grants taken while fetch was waiting.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            starve_cnt_r <= {CNT_W{1'b0}};
        end else if (gnt == GNT_FETCH) begin
            starve_cnt_r <= {CNT_W{1'b0}};
        end else if ((gnt == GNT_LOAD) && f_req_valid && !age_win_s
                     && (starve_cnt_r != CNT_W'(STARVE_MAX))) begin
            starve_cnt_r <= starve_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            starve_cnt_r <= starve_cnt_r;
        end
    end
`else
    localparam int UNUSED_STARVE_MAX = STARVE_MAX;

    logic age_win_s;
    logic unused_sel_bits_s;

    assign age_win_s         = 1'b0;
    assign unused_sel_bits_s = clk ^ rst_n;
`endif

    // Grant only in IDLE; an aged fetch overrides the loader.
    always_comb begin
        gnt = GNT_NONE;
        if (!idle) begin
            gnt = GNT_NONE;
        end else if (age_win_s) begin
            gnt = GNT_FETCH;
        end else if (l_req_valid) begin
            gnt = GNT_LOAD;
        end else if (f_req_valid) begin
            gnt = GNT_FETCH;
        end else begin
            gnt = GNT_NONE;
        end
    end

endmodule

// File: rtl/imem_arbiter.sv
// Arbiter/sequencer sharing the single-port 16K x 32 instruction RAM between fetch
// and the program loader. Optional fetch starvation protection: IMEM_ARB_AGE_EN.
module imem_arbiter
    import imem_pkg::*;
#(
    parameter int IDX_W      = imem_pkg::IDX_W,
    parameter int DATA_W     = imem_pkg::DATA_W,
    parameter int STARVE_MAX = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    imem_arbiter_if.slave  bus
);

    state_t            state_r;
    logic              rsp_valid_r;
    logic              rsp_err_r;
    logic [DATA_W-1:0] rsp_data_r;
    logic              wr_ack_r;

    gnt_t              gnt_s;
    logic              idle_s;
    logic              f_aligned_s;
    logic              mem_en_s;
    logic              mem_we_s;
    logic [IDX_W-1:0]  mem_idx_s;
    logic [DATA_W-1:0] mem_wdata_s;
    logic              unused_addr_bits_s;

    // Gating with rst_n keeps both ready outputs and the RAM strobe low during reset.
    assign idle_s      = rst_n && (state_r == IDLE);
    assign f_aligned_s = (bus.f_req_addr[1:0] == 2'b00);

    imem_arb_sel #(
        .STARVE_MAX (STARVE_MAX)
    ) u_sel (
        .clk         (clk),
        .rst_n       (rst_n),
        .idle        (idle_s),
        .f_req_valid (bus.f_req_valid),
        .l_req_valid (bus.l_req_valid),
        .gnt         (gnt_s)
    );

    // RAM strobes follow the grant in the same cycle; idle bus is all zeros.
    always_comb begin
        mem_en_s    = 1'b0;
        mem_we_s    = 1'b0;
        mem_idx_s   = {IDX_W{1'b0}};
        mem_wdata_s = {DATA_W{1'b0}};
        case (gnt_s)
            GNT_LOAD: begin
                mem_en_s    = 1'b1;
                mem_we_s    = 1'b1;
                mem_idx_s   = bus.l_req_addr[IDX_W+1:2];
                mem_wdata_s = bus.l_req_data;
            end
            GNT_FETCH: begin
                if (f_aligned_s) begin
                    mem_en_s  = 1'b1;
                    mem_idx_s = bus.f_req_addr[IDX_W+1:2];
                end else begin
                    mem_en_s  = 1'b0;
                end
            end
            default: begin
                mem_en_s = 1'b0;
            end
        endcase
    end

    // Sequencer FSM with the held fetch response and the write acknowledge pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            rsp_valid_r <= 1'b0;
            rsp_err_r   <= 1'b0;
            rsp_data_r  <= {DATA_W{1'b0}};
            wr_ack_r    <= 1'b0;
        end else begin
            wr_ack_r <= (gnt_s == GNT_LOAD);
            case (state_r)
                IDLE: begin
                    if (gnt_s == GNT_FETCH) begin
                        if (f_aligned_s) begin
                            state_r <= RD;
                        end else begin
                            state_r     <= RSP;
                            rsp_valid_r <= 1'b1;
                            rsp_err_r   <= 1'b1;
                            rsp_data_r  <= {DATA_W{1'b0}};
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                RD: begin
                    rsp_data_r  <= bus.mem_rdata;
                    rsp_err_r   <= 1'b0;
                    rsp_valid_r <= 1'b1;
                    state_r     <= RSP;
                end
                RSP: begin
                    if (bus.f_rsp_ready) begin
                        rsp_valid_r <= 1'b0;
                        state_r     <= IDLE;
                    end else begin
                        state_r <= RSP;
                    end
                end
                default: begin
                    rsp_valid_r <= 1'b0;
                    state_r     <= IDLE;
                end
            endcase
        end
    end

    assign bus.f_req_ready = (gnt_s == GNT_FETCH);
    assign bus.l_req_ready = (gnt_s == GNT_LOAD);
    assign bus.f_rsp_valid = rsp_valid_r;
    assign bus.f_rsp_data  = rsp_data_r;
    assign bus.f_rsp_err   = rsp_err_r;
    assign bus.l_wr_ack    = wr_ack_r;
    assign bus.mem_en      = mem_en_s;
    assign bus.mem_we      = mem_we_s;
    assign bus.mem_idx     = mem_idx_s;
    assign bus.mem_wdata   = mem_wdata_s;

    // Address bits outside the 64 KB window (and loader byte offset) are don't-care.
    assign unused_addr_bits_s = ^{bus.f_req_addr[31:16], bus.l_req_addr[31:16],
                                  bus.l_req_addr[1:0]};

endmodule

// File: tb/tb_imem_arbiter.sv
// Bench for imem_arbiter: directed steps plus random traffic checked against a
// transaction-level reference model with its own memory image.
module tb_imem_arbiter;

    localparam int STARVE_MAX = 4;
`ifdef IMEM_ARB_AGE_EN
    localparam bit AGE = 1'b1;
`else
    localparam bit AGE = 1'b0;
`endif

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    imem_arbiter_if bus();

    imem_arbiter #(.STARVE_MAX(STARVE_MAX)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM contents never written by the loader come from a fixed background pattern.
    function automatic logic [31:0] bg_word(input int i);
        return 32'h5A5A_0000 ^ (i * 32'h0001_0003);
    endfunction

    // Synchronous single-port RAM the arbiter drives.
    logic [31:0] ram [16384];
    bit          ram_wr [16384];
    always @(posedge clk) begin
        if (bus.mem_en) begin
            if (bus.mem_we) begin
                ram[bus.mem_idx]    <= bus.mem_wdata;
                ram_wr[bus.mem_idx] <= 1'b1;
            end else begin
                bus.mem_rdata <= ram_wr[bus.mem_idx] ? ram[bus.mem_idx] : bg_word(int'(bus.mem_idx));
            end
        end
    end

    // Reference model: memory image plus response/ack/starvation bookkeeping.
    logic [31:0] ref_mem [int];
    bit          m_busy;
    int          m_cd;
    logic [31:0] m_data;
    bit          m_err;
    bit          m_ack;
    int          m_starve;
    int          fgnt_seen;

    function automatic logic [31:0] ref_rd(input int i);
        return ref_mem.exists(i) ? ref_mem[i] : bg_word(i);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_busy   = 1'b0;
        m_cd     = 0;
        m_ack    = 1'b0;
        m_starve = 0;
    endtask

    task automatic reset_cycle(input bit fv, input bit lv);
        rst_n           = 1'b0;
        bus.f_req_valid = fv;
        bus.l_req_valid = lv;
        bus.f_req_addr  = 32'h0000_0000;
        bus.l_req_addr  = 32'h0000_0000;
        #1;
        chk("rst_l_req_ready", {31'd0, bus.l_req_ready}, 32'd0);
        chk("rst_f_req_ready", {31'd0, bus.f_req_ready}, 32'd0);
        chk("rst_mem_en", {31'd0, bus.mem_en}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    // One clock cycle: drive, check every output against the model, advance.
    task automatic step(input bit fv, input logic [31:0] fa, input bit fr,
                        input bit lv, input logic [31:0] la, input logic [31:0] ld);
        bit          g_l;
        bit          g_f;
        bit          exp_en;
        bit          exp_valid;
        logic [31:0] exp_idx;
        int          fi;
        int          li;
        bus.f_req_valid = fv;
        bus.f_req_addr  = fa;
        bus.f_rsp_ready = fr;
        bus.l_req_valid = lv;
        bus.l_req_addr  = la;
        bus.l_req_data  = ld;
        #1;
        g_l = 1'b0;
        g_f = 1'b0;
        if (!m_busy) begin
            if (fv && AGE && (m_starve == STARVE_MAX)) g_f = 1'b1;
            else if (lv) g_l = 1'b1;
            else if (fv) g_f = 1'b1;
        end
        fi        = int'(fa[15:2]);
        li        = int'(la[15:2]);
        exp_en    = g_l || (g_f && (fa[1:0] == 2'b00));
        exp_idx   = g_l ? li : (exp_en ? fi : 0);
        exp_valid = m_busy && (m_cd == 0);
        chk("l_req_ready", {31'd0, bus.l_req_ready}, {31'd0, g_l});
        chk("f_req_ready", {31'd0, bus.f_req_ready}, {31'd0, g_f});
        chk("mem_en", {31'd0, bus.mem_en}, {31'd0, exp_en});
        chk("mem_we", {31'd0, bus.mem_we}, {31'd0, g_l});
        chk("mem_idx", {18'd0, bus.mem_idx}, exp_idx);
        chk("mem_wdata", bus.mem_wdata, g_l ? ld : 32'd0);
        chk("l_wr_ack", {31'd0, bus.l_wr_ack}, {31'd0, m_ack});
        chk("f_rsp_valid", {31'd0, bus.f_rsp_valid}, {31'd0, exp_valid});
        if (exp_valid) begin
            chk("f_rsp_data", bus.f_rsp_data, m_data);
            chk("f_rsp_err", {31'd0, bus.f_rsp_err}, {31'd0, m_err});
        end
        if (bus.f_req_ready === 1'b1) fgnt_seen++;
        m_ack = g_l;
        if (g_l) begin
            ref_mem[li] = ld;
            if (fv && (m_starve < STARVE_MAX)) m_starve++;
        end else if (g_f) begin
            m_starve = 0;
            m_busy   = 1'b1;
            if (fa[1:0] == 2'b00) begin
                m_cd   = 1;
                m_data = ref_rd(fi);
                m_err  = 1'b0;
            end else begin
                m_cd   = 0;
                m_data = 32'd0;
                m_err  = 1'b1;
            end
        end else if (m_busy) begin
            if (m_cd > 0) m_cd--;
            else if (fr) m_busy = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_step(input bit fr);
        step(1'b0, 32'd0, fr, 1'b0, 32'd0, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired before test completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r;
        logic [31:0] q;
        logic [31:0] fa;
        logic [31:0] la;
        int          f0;
        total           = 0;
        bad             = 0;
        fgnt_seen       = 0;
        rst_n           = 1'b0;
        bus.f_req_valid = 1'b0;
        bus.f_req_addr  = 32'd0;
        bus.f_rsp_ready = 1'b0;
        bus.l_req_valid = 1'b0;
        bus.l_req_addr  = 32'd0;
        bus.l_req_data  = 32'd0;
        model_reset();
        @(posedge clk);
        #1;
        reset_cycle(1'b1, 1'b1);
        reset_cycle(1'b1, 1'b1);
        chk("reset_rsp_valid", {31'd0, bus.f_rsp_valid}, 32'd0);
        chk("reset_rsp_data", bus.f_rsp_data, 32'd0);
        chk("reset_rsp_err", {31'd0, bus.f_rsp_err}, 32'd0);
        chk("reset_wr_ack", {31'd0, bus.l_wr_ack}, 32'd0);

        // Word 4 = 0x2001_0005, then aligned fetch of 0x10 (three-cycle turnaround).
        step(1'b0, 32'd0, 1'b1, 1'b1, 32'h0000_0010, 32'h2001_0005);
        step(1'b1, 32'h0000_0010, 1'b1, 1'b0, 32'd0, 32'd0);
        idle_step(1'b1);
        idle_step(1'b1);
        idle_step(1'b1);

        // Misaligned fetch: no RAM access, error response next cycle.
        step(1'b1, 32'h0000_0012, 1'b1, 1'b0, 32'd0, 32'd0);
        idle_step(1'b1);
        idle_step(1'b1);

        // Write then fetch through the 64 KB wrap to the same index 0x40.
        step(1'b0, 32'd0, 1'b1, 1'b1, 32'h0000_0100, 32'hDEAD_BEEF);
        step(1'b1, 32'h0001_0100, 1'b1, 1'b0, 32'd0, 32'd0);
        idle_step(1'b1);
        idle_step(1'b1);
        idle_step(1'b1);

        // Response held 5 cycles with a pending loader; write wins first IDLE cycle.
        step(1'b1, 32'h0000_0100, 1'b0, 1'b0, 32'd0, 32'd0);
        idle_step(1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, 32'd0, 1'b0, 1'b1, 32'h0000_0200, 32'h1234_5678);
        step(1'b0, 32'd0, 1'b1, 1'b1, 32'h0000_0200, 32'h1234_5678);
        step(1'b0, 32'd0, 1'b1, 1'b1, 32'h0000_0200, 32'h1234_5678);
        idle_step(1'b1);

        // Both requesters always valid for 15 cycles.
        f0 = fgnt_seen;
        for (int i = 0; i < 15; i++) step(1'b1, 32'h0000_0020, 1'b1, 1'b1, 32'h0000_0024, 32'hA000_0000 + i);
        chk("contention_fetch_grants", fgnt_seen - f0, AGE ? 32'd2 : 32'd0);
        idle_step(1'b1);
        idle_step(1'b1);
        idle_step(1'b1);

        // Reset while in RD: the pending read must never surface.
        step(1'b1, 32'h0000_0024, 1'b1, 1'b0, 32'd0, 32'd0);
        reset_cycle(1'b1, 1'b1);
        idle_step(1'b1);
        idle_step(1'b1);
        idle_step(1'b1);

        // Random traffic over a small index window to exercise read-after-write.
        for (int n = 0; n < 400; n++) begin
            r  = $urandom();
            q  = $urandom();
            fa = (q & 32'hFFFF_0000) | {26'd0, r[12:9], 2'b00};
            if (q[3:2] == 2'b00) fa = fa | {30'd0, q[1:0]};
            la = (q & 32'hFFFF_0003) | {26'd0, r[16:13], 2'b00};
            if (r[31:26] == 6'd0) reset_cycle(r[0], r[1]);
            else step(r[0], fa, (r[3:2] != 2'b00), r[4], la, $urandom());
        end
        idle_step(1'b1);
        idle_step(1'b1);
        idle_step(1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
